uart_mem_bridge: RTL and testbench

//  Byte-stream command engine between the host serial link (after the rx FIFO) and the SDRAM controller.

---
 rtl/uart_bridge_pkg.sv | 43 ++++
 rtl/uart_bridge_lane.sv | 35 +++
 rtl/uart_mem_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// uart_bridge_pkg : framing characters, FSM state type and lane-width helper
//                   shared by the UART-to-memory bridge.
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

   localparam logic [7:0] CH_START = 8'h21;  // '!'
   localparam logic [7:0] CH_READ  = 8'h52;  // 'R'
   localparam logic [7:0] CH_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] CH_FILL  = 8'h46;  // 'F'
   localparam logic [7:0] CH_VER   = 8'h56;  // 'V'
   localparam logic [7:0] CH_ACK_W = 8'h77;  // 'w'
   localparam logic [7:0] CH_ACK_F = 8'h66;  // 'f'
   localparam logic [7:0] CH_UNK   = 8'h3F;  // '?'

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_ADDR,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_TX,
      ST_WR_GET,
      ST_WR_REQ,
      ST_FILL_GET,
      ST_FILL_REQ,
      ST_VER,
      ST_CKSUM,
      ST_ACK
   } state_t;

   // Lane-select width; a one-byte memory still gets a 1-bit (tied-off) lane.
   function automatic int lane_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bridge_lane.sv
// ============================================================================
// uart_bridge_lane : byte-lane replicate/mask for writes and lane extract for
//                    reads on a DATA_BYTES-wide memory word.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_bridge_lane
   import uart_bridge_pkg::*;
#(
   parameter int DATA_BYTES = 2
) (
   input  logic [lane_bits(DATA_BYTES)-1:0] lane,
   input  logic [7:0]                       wr_byte,
   input  logic [8*DATA_BYTES-1:0]          rd_word,
   output logic [8*DATA_BYTES-1:0]          wr_word,
   output logic [DATA_BYTES-1:0]            wr_mask,
   output logic [7:0]                       rd_byte
);

   assign wr_word = {DATA_BYTES{wr_byte}};

   generate
      if (DATA_BYTES == 1) begin : g_single
         assign wr_mask = '1;
         assign rd_byte = rd_word[7:0];
      end else begin : g_multi
         assign wr_mask = DATA_BYTES'(1) << lane;
         assign rd_byte = rd_word[8*lane +: 8];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_mem_bridge.sv
// ============================================================================
// uart_mem_bridge : framed byte-stream command engine (R/W/F/V) driving a
//                   byte-addressed memory. Optional checksum: UART_BRIDGE_CKSUM_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_mem_bridge
   import uart_bridge_pkg::*;
#(
   parameter int         ADDR_BITS  = 32,
   parameter int         ADDR_BYTES = 4,
   parameter int         LEN_BYTES  = 3,
   parameter int         DATA_BYTES = 2,
   parameter logic [7:0] VERSION    = 8'h31,
   parameter int         VER_LEN    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [ADDR_BITS-1:0]    mem_addr,
   output logic [8*DATA_BYTES-1:0] mem_wr_data,
   output logic [DATA_BYTES-1:0]   mem_wr_mask,
   output logic                    mem_we,
   output logic                    mem_enable,
   input  logic [8*DATA_BYTES-1:0] mem_rd_data,
   input  logic                    mem_ack,
   input  logic                    mem_idle
);

   localparam int LEN_W  = 8 * LEN_BYTES;
   localparam int LANE_W = lane_bits(DATA_BYTES);

   state_t                  state, state_n;
   logic [LEN_W-1:0]        len;
   logic [7:0]              cmd;
   logic [7:0]              wr_byte;
   logic [7:0]              fld_cnt;
   logic [7:0]              ver_cnt;
   logic [7:0]              sum;
   logic [7:0]              ack_char;
   logic                    rx_fire, tx_fire, mem_go;
   logic                    fld_last, len_zero, len_last;
   logic [LANE_W-1:0]       lane;
   logic [8*DATA_BYTES-1:0] wr_word;
   logic [DATA_BYTES-1:0]   wr_mask;
   logic [7:0]              rd_byte;

   assign rx_ready = !reset && (state inside {ST_IDLE, ST_CMD, ST_LEN, ST_ADDR,
                                              ST_WR_GET, ST_FILL_GET});
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign mem_go   = mem_idle && !mem_enable;
   assign fld_last = (state == ST_LEN) ? (fld_cnt == 8'(LEN_BYTES - 1))
                                       : (fld_cnt == 8'(ADDR_BYTES - 1));
   assign len_zero = (len == '0);
   assign len_last = (len == LEN_W'(1));
   assign ack_char = (cmd == CH_WRITE) ? CH_ACK_W : CH_ACK_F;

`ifdef UART_BRIDGE_CKSUM_EN
   localparam state_t POST_RD = ST_CKSUM;
   localparam state_t POST_WF = ST_CKSUM;

   // A zero-length fill contributes nothing, so its reported sum stays 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum <= 8'h00;
      end else if (state == ST_IDLE && rx_fire && rx_data == CH_START) begin
         sum <= 8'h00;
      end else if (state == ST_RD_WAIT && mem_ack) begin
         sum <= sum + rd_byte;
      end else if (rx_fire && (state == ST_WR_GET ||
                               (state == ST_FILL_GET && !len_zero))) begin
         sum <= sum + rx_data;
      end
   end
`else
   localparam state_t POST_RD = ST_IDLE;
   localparam state_t POST_WF = ST_ACK;

   assign sum = 8'h00;
`endif

   generate
      if (DATA_BYTES > 1) begin : g_lane_sel
         assign lane = mem_addr[LANE_W-1:0];
      end else begin : g_lane_fixed
         assign lane = '0;
      end
   endgenerate

   uart_bridge_lane #(
      .DATA_BYTES(DATA_BYTES)
   ) u_lane (
      .lane   (lane),
      .wr_byte(wr_byte),
      .rd_word(mem_rd_data),
      .wr_word(wr_word),
      .wr_mask(wr_mask),
      .rd_byte(rd_byte)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:     if (rx_fire && rx_data == CH_START) state_n = ST_CMD;
         ST_CMD: begin
            if (rx_fire) begin
               case (rx_data)
                  CH_READ, CH_WRITE, CH_FILL: state_n = ST_LEN;
                  CH_VER:                     state_n = ST_VER;
                  default:                    state_n = ST_ACK;
               endcase
            end
         end
         ST_LEN:      if (rx_fire && fld_last) state_n = ST_ADDR;
         ST_ADDR: begin
            if (rx_fire && fld_last) begin
               if (cmd == CH_READ)       state_n = len_zero ? POST_RD : ST_RD_REQ;
               else if (cmd == CH_WRITE) state_n = len_zero ? POST_WF : ST_WR_GET;
               else                      state_n = ST_FILL_GET;
            end
         end
         ST_RD_REQ:   if (mem_go)  state_n = ST_RD_WAIT;
         ST_RD_WAIT:  if (mem_ack) state_n = ST_RD_TX;
         // len was already decremented at the ack edge
         ST_RD_TX:    if (tx_fire) state_n = len_zero ? POST_RD : ST_RD_REQ;
         ST_WR_GET:   if (rx_fire) state_n = ST_WR_REQ;
         ST_WR_REQ:   if (mem_ack) state_n = len_last ? POST_WF : ST_WR_GET;
         ST_FILL_GET: if (rx_fire) state_n = len_zero ? POST_WF : ST_FILL_REQ;
         ST_FILL_REQ: if (mem_ack && len_last) state_n = POST_WF;
         ST_VER:      if (tx_fire && ver_cnt == 8'(VER_LEN - 1)) state_n = ST_IDLE;
         ST_CKSUM:    if (tx_fire) state_n = (cmd == CH_READ) ? ST_IDLE : ST_ACK;
         ST_ACK:      if (tx_fire) state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_data     <= 8'h00;
         tx_valid    <= 1'b0;
         mem_enable  <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_wr_mask <= '0;
         len         <= '0;
         cmd         <= 8'h00;
         wr_byte     <= 8'h00;
         fld_cnt     <= 8'h00;
         ver_cnt     <= 8'h00;
      end else begin
         if (tx_fire) tx_valid <= 1'b0;
         case (state)
            ST_CMD: begin
               if (rx_fire) begin
                  cmd     <= rx_data;
                  fld_cnt <= 8'h00;
               end
            end
            ST_LEN: begin
               if (rx_fire) begin
                  len     <= LEN_W'({len, rx_data});
                  fld_cnt <= fld_last ? 8'h00 : fld_cnt + 8'd1;
               end
            end
            ST_ADDR: begin
               // Truncating the shift drops address bits above ADDR_BITS.
               if (rx_fire) begin
                  mem_addr <= ADDR_BITS'({mem_addr, rx_data});
                  fld_cnt  <= fld_cnt + 8'd1;
               end
            end
            ST_RD_REQ: begin
               if (mem_go) begin
                  mem_enable <= 1'b1;
                  mem_we     <= 1'b0;
               end
            end
            ST_RD_WAIT: begin
               if (mem_ack) begin
                  mem_enable <= 1'b0;
                  mem_addr   <= mem_addr + ADDR_BITS'(1);
                  len        <= len - LEN_W'(1);
                  tx_data    <= rd_byte;
                  tx_valid   <= 1'b1;
               end
            end
            ST_WR_GET, ST_FILL_GET: if (rx_fire) wr_byte <= rx_data;
            ST_WR_REQ, ST_FILL_REQ: begin
               if (mem_ack) begin
                  mem_enable <= 1'b0;
                  mem_addr   <= mem_addr + ADDR_BITS'(1);
                  len        <= len - LEN_W'(1);
               end else if (mem_go) begin
                  mem_enable  <= 1'b1;
                  mem_we      <= 1'b1;
                  mem_wr_data <= wr_word;
                  mem_wr_mask <= wr_mask;
               end
            end
            ST_VER: begin
               if (tx_fire && ver_cnt != 8'(VER_LEN - 1)) begin
                  ver_cnt  <= ver_cnt + 8'd1;
                  tx_valid <= 1'b1;
               end
            end
            default: ;
         endcase

         // Response bytes are loaded on entry to each sending state.
         if (state_n != state) begin
            case (state_n)
               ST_VER: begin
                  tx_data  <= VERSION;
                  tx_valid <= 1'b1;
                  ver_cnt  <= 8'h00;
               end
               ST_CKSUM: begin
                  tx_data  <= sum;
                  tx_valid <= 1'b1;
               end
               ST_ACK: begin
                  tx_data  <= (state == ST_CMD) ? CH_UNK : ack_char;
                  tx_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
// ============================================================================
// tb_uart_mem_bridge : scoreboard bench for uart_mem_bridge with a 2-byte-wide
//                      memory responder model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_mem_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] mem_addr;
   logic [15:0] mem_wr_data;
   logic [1:0]  mem_wr_mask;
   logic        mem_we;
   logic        mem_enable;
   logic [15:0] mem_rd_data;
   logic        mem_ack;
   logic        mem_idle;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_tx[$];
   logic [7:0]  act_tx[$];
   logic [49:0] exp_wr[$];
   logic [49:0] act_wr[$];

   logic [7:0]  model [256];
   logic        ack_hold;
   int          lat;

   uart_mem_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .mem_addr   (mem_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr_mask(mem_wr_mask),
      .mem_we     (mem_we),
      .mem_enable (mem_enable),
      .mem_rd_data(mem_rd_data),
      .mem_ack    (mem_ack),
      .mem_idle   (mem_idle)
   );

   always #5 clk = ~clk;

   // Memory responder: ack two cycles after a request is seen.
   always @(posedge clk) begin
      if (reset) begin
         mem_ack <= 1'b0;
         lat     <= 0;
      end else begin
         mem_ack <= 1'b0;
         if (mem_enable && !mem_ack && !ack_hold) begin
            if (lat == 2) begin
               lat     <= 0;
               mem_ack <= 1'b1;
               if (mem_we) begin
                  if (mem_wr_mask[0]) model[{mem_addr[7:1], 1'b0}] <= mem_wr_data[7:0];
                  if (mem_wr_mask[1]) model[{mem_addr[7:1], 1'b1}] <= mem_wr_data[15:8];
               end else begin
                  mem_rd_data <= {model[{mem_addr[7:1], 1'b1}], model[{mem_addr[7:1], 1'b0}]};
               end
            end else begin
               lat <= lat + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && tx_valid && tx_ready) act_tx.push_back(tx_data);
      if (!reset && mem_enable && mem_we && mem_ack)
         act_wr.push_back({mem_addr, mem_wr_mask, mem_wr_data});
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         failures++;
         $display("FAIL rx_accept timeout byte=%h", b);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] c, input logic [23:0] l, input logic [31:0] a);
      send_byte(8'h21);
      send_byte(c);
      send_byte(l[23:16]); send_byte(l[15:8]); send_byte(l[7:0]);
      send_byte(a[31:24]); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
   endtask

   task automatic wait_out(input int ntx, input int nwr);
      int n = 0;
      while ((act_tx.size() < ntx || act_wr.size() < nwr) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("FAIL output_timeout tx_got=%0d tx_need=%0d wr_got=%0d wr_need=%0d",
                  act_tx.size(), ntx, act_wr.size(), nwr);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks += 8;
      if (rx_ready !== 1'b0)     begin failures++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
      if (tx_valid !== 1'b0)     begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
      if (tx_data !== 8'h00)     begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
      if (mem_enable !== 1'b0)   begin failures++; $display("FAIL rst_mem_enable got=%b exp=0", mem_enable); end
      if (mem_we !== 1'b0)       begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      if (mem_addr !== 32'h0)    begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      if (mem_wr_data !== 16'h0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", mem_wr_data); end
      if (mem_wr_mask !== 2'b00) begin failures++; $display("FAIL rst_wr_mask got=%b exp=0", mem_wr_mask); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1) begin failures++; $display("FAIL idle_rx_ready got=%b exp=1", rx_ready); end
   endtask

   task automatic test_write();
      logic [49:0] ew, aw;
      logic [7:0]  e, a;
      exp_wr.push_back({32'h10, 2'b01, 16'hAAAA});
      exp_wr.push_back({32'h11, 2'b10, 16'hBBBB});
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h65);
`endif
      exp_tx.push_back(8'h77);
      send_hdr(8'h57, 24'd2, 32'h10);
      send_byte(8'hAA);
      send_byte(8'hBB);
      wait_out(exp_tx.size(), exp_wr.size());
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front();
         aw = (act_wr.size() != 0) ? act_wr.pop_front() : 50'h0;
         checks++;
         if (aw !== ew) begin failures++; $display("FAIL write_op got=%h exp=%h", aw, ew); end
      end
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL write_tx got=%h exp=%h", a, e); end
      end
   endtask

   task automatic test_read();
      logic [7:0] e, a;
      int n = 0;
      int bad = 0;
      exp_tx.push_back(8'hAA);
      exp_tx.push_back(8'hBB);
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h65);
`endif
      tx_ready = 1'b0;
      send_hdr(8'h52, 24'd2, 32'h10);
      while (!tx_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (5) begin
         @(negedge clk);
         if (mem_enable !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hAA) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL read_hold bad_cycles=%0d exp=0 (tx_valid=%b tx_data=%h mem_enable=%b)",
                  bad, tx_valid, tx_data, mem_enable);
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_out(exp_tx.size(), 0);
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL read_tx got=%h exp=%h", a, e); end
      end
   endtask

   task automatic test_fill();
      logic [49:0] ew, aw;
      logic [7:0]  e, a;
      exp_wr.push_back({32'hFFFF_FFFE, 2'b01, 16'h5C5C});
      exp_wr.push_back({32'hFFFF_FFFF, 2'b10, 16'h5C5C});
      exp_wr.push_back({32'h0000_0000, 2'b01, 16'h5C5C});
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h5C);
`endif
      exp_tx.push_back(8'h66);
      send_hdr(8'h46, 24'd3, 32'hFFFF_FFFE);
      send_byte(8'h5C);
      wait_out(exp_tx.size(), exp_wr.size());
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front();
         aw = (act_wr.size() != 0) ? act_wr.pop_front() : 50'h0;
         checks++;
         if (aw !== ew) begin failures++; $display("FAIL fill_op got=%h exp=%h", aw, ew); end
      end
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL fill_tx got=%h exp=%h", a, e); end
      end
   endtask

   task automatic test_version();
      logic [7:0] e, a;
      send_byte(8'h41);
      repeat (20) @(negedge clk);
      checks++;
      if (act_tx.size() != 0) begin
         failures++;
         $display("FAIL stray_byte tx_count=%0d exp=0", act_tx.size());
      end
      repeat (8) exp_tx.push_back(8'h31);
      exp_tx.push_back(8'h3F);
      send_byte(8'h21);
      send_byte(8'h56);
      send_byte(8'h21);
      send_byte(8'h51);
      wait_out(exp_tx.size(), 0);
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL version_tx got=%h exp=%h", a, e); end
      end
      checks++;
      if (act_tx.size() != 0) begin failures++; $display("FAIL version_extra count=%0d exp=0", act_tx.size()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e, a;
      int n = 0;
      ack_hold = 1'b1;
      send_hdr(8'h52, 24'd1, 32'h10);
      while (!mem_enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks += 2;
      if (mem_enable !== 1'b0) begin failures++; $display("FAIL midrst_mem_enable got=%b exp=0", mem_enable); end
      if (tx_valid !== 1'b0)   begin failures++; $display("FAIL midrst_tx_valid got=%b exp=0", tx_valid); end
      @(negedge clk);
      reset    = 1'b0;
      ack_hold = 1'b0;
      repeat (8) exp_tx.push_back(8'h31);
      send_byte(8'h21);
      send_byte(8'h56);
      wait_out(exp_tx.size(), 0);
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL midrst_ver_tx got=%h exp=%h", a, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [49:0] ew, aw;
      logic [7:0]  e, a;
      // Zero-length commands: no memory traffic, acks only.
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h00);
`endif
      exp_tx.push_back(8'h77);
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
`endif
      exp_tx.push_back(8'h66);
      send_hdr(8'h57, 24'd0, 32'h20);
      send_hdr(8'h52, 24'd0, 32'h20);
      send_hdr(8'h46, 24'd0, 32'h20);
      send_byte(8'h77);
      wait_out(exp_tx.size(), 0);
      checks++;
      if (act_wr.size() != 0) begin failures++; $display("FAIL zero_len_writes count=%0d exp=0", act_wr.size()); end
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL zero_len_tx got=%h exp=%h", a, e); end
      end
      // Memory busy: no request until mem_idle returns.
      mem_idle = 1'b0;
      exp_wr.push_back({32'h31, 2'b10, 16'h1212});
`ifdef UART_BRIDGE_CKSUM_EN
      exp_tx.push_back(8'h12);
`endif
      exp_tx.push_back(8'h77);
      send_hdr(8'h57, 24'd1, 32'h31);
      send_byte(8'h12);
      repeat (10) @(negedge clk);
      checks++;
      if (mem_enable !== 1'b0) begin failures++; $display("FAIL busy_mem_enable got=%b exp=0", mem_enable); end
      mem_idle = 1'b1;
      wait_out(exp_tx.size(), exp_wr.size());
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front();
         aw = (act_wr.size() != 0) ? act_wr.pop_front() : 50'h0;
         checks++;
         if (aw !== ew) begin failures++; $display("FAIL busy_write_op got=%h exp=%h", aw, ew); end
      end
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         a = (act_tx.size() != 0) ? act_tx.pop_front() : 8'h00;
         checks++;
         if (a !== e) begin failures++; $display("FAIL busy_write_tx got=%h exp=%h", a, e); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      mem_idle = 1'b1;
      ack_hold = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_version();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
